// File: rtl/iomem_pkg.sv
// iomem_pkg: shared types and constants for the iomem_fabric interconnect.
//   state_t          - request FSM states (IDLE, ACCESS, RESP)
//   ERR_SLOT_DECODE  - err_slot value recorded for a decode error
//   ST_*             - bit positions inside status word 0
//   status_word0()   - packs the error log into status word 0
package iomem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] ERR_SLOT_DECODE = 4'hF;

    // Status word 0 layout: {err_to, 15'b0, 4'b0, err_slot, err_count}
    localparam int ST_TO_BIT    = 31;
    localparam int ST_SLOT_LSB  = 8;
    localparam int ST_COUNT_LSB = 0;

    function automatic logic [31:0] status_word0(input logic       to,
                                                 input logic [3:0] slot,
                                                 input logic [7:0] count);
        logic [31:0] w;
        w = '0;
        w[ST_TO_BIT]           = to;
        w[ST_SLOT_LSB +: 4]    = slot;
        w[ST_COUNT_LSB +: 8]   = count;
        return w;
    endfunction

endpackage

// File: rtl/iomem_if.sv
// iomem_if: bus bundle between the picorv32 native memory port, the fabric
// and the peripheral slaves.
//   m_valid/m_addr/m_wdata/m_wstrb  master request (m_wstrb == 0 is a read)
//   m_ready/m_rdata                 one-cycle completion pulse with read data
//   s_valid (one-hot)               per-slave request
//   s_addr/s_wdata/s_wstrb          registered request, shared by all slaves
//   s_ready/s_rdata                 per-slave completion and packed read data
//
// Handshake: a request is presented by holding valid high; the responder
// completes it with a single-cycle ready.  The master holds m_valid and its
// payload stable until it sees m_ready, then drops m_valid.  A slave sees
// s_valid[i] held until it returns s_ready[i] (or the fabric abandons the
// request on timeout or reset); s_ready on a slave whose s_valid is low is
// ignored.  Only one request is outstanding at a time.
//   modports: fabric (the interconnect), master (CPU side), slave (peripherals)
interface iomem_if #(
    parameter int NSLAVES = 8
) ();
    logic                   m_valid;
    logic [31:0]            m_addr;
    logic [31:0]            m_wdata;
    logic [3:0]             m_wstrb;
    logic                   m_ready;
    logic [31:0]            m_rdata;

    logic [NSLAVES-1:0]     s_valid;
    logic [31:0]            s_addr;
    logic [31:0]            s_wdata;
    logic [3:0]             s_wstrb;
    logic [NSLAVES-1:0]     s_ready;
    logic [32*NSLAVES-1:0]  s_rdata;

    modport fabric (
        input  m_valid, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rdata,
        output s_valid, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rdata
    );

    modport slave (
        input  s_valid, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );
endinterface

// File: rtl/iomem_decode.sv
// iomem_decode: combinational priority address decoder.
//   addr  in   byte address to decode
//   hit   out  at least one slot matches
//   sel   out  index of the lowest-numbered matching slot (0 when no hit)
// Slot i matches when (addr & MASK_i) == (BASE_i & MASK_i).
module iomem_decode
    import iomem_pkg::*;
#(
    parameter int                    NSLAVES = 8,
    parameter logic [32*NSLAVES-1:0] BASE    = {NSLAVES{32'h0}},
    parameter logic [32*NSLAVES-1:0] MASK    = {NSLAVES{32'hFFFF_FFFF}}
) (
    input  logic [31:0] addr,
    output logic        hit,
    output logic [3:0]  sel
);

    // Walk from the highest slot down so the lowest match is the last write.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((addr & MASK[32*i +: 32]) == (BASE[32*i +: 32] & MASK[32*i +: 32])) begin
                hit = 1'b1;
                sel = 4'(i);
            end
        end
    end

endmodule

// File: rtl/iomem_fabric.sv
// iomem_fabric: single-outstanding I/O interconnect between the picorv32
// native memory port and NSLAVES memory-mapped peripherals.
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   bus        fabric modport of iomem_if (master request/response and
//              per-slave request/response signals)
//   err_pulse  out  one-cycle pulse on every decode error or timeout
//   dbg_state  out  current FSM state
// Requests are decoded against a base/mask table; the status register pair
// at STATUS_ADDR/STATUS_ADDR+4 logs the last decode error or slave timeout.
// Every output comes straight from a register.
module iomem_fabric
    import iomem_pkg::*;
#(
    parameter int                    NSLAVES     = 8,
    parameter int                    TIMEOUT     = 1023,
    parameter logic [32*NSLAVES-1:0] BASE        = {NSLAVES{32'h0}},
    parameter logic [32*NSLAVES-1:0] MASK        = {NSLAVES{32'hFFFF_FFFF}},
    parameter logic [31:0]           STATUS_ADDR = 32'h0300_0100,
    parameter logic [31:0]           ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic           clk,
    input  logic           reset,
    iomem_if.fabric        bus,
    output logic           err_pulse,
    output state_t         dbg_state
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    // The counter starts at 0 in the first ACCESS cycle, so the last
    // permitted cycle of a TIMEOUT-cycle access sees TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state, state_n;
    logic [3:0]           sel, sel_n;
    logic [NSLAVES-1:0]   s_valid_q, s_valid_n;
    logic [31:0]          s_addr_q, s_addr_n;
    logic [31:0]          s_wdata_q, s_wdata_n;
    logic [3:0]           s_wstrb_q, s_wstrb_n;
    logic                 m_ready_q, m_ready_n;
    logic [31:0]          m_rdata_q, m_rdata_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic                 err_pulse_q, err_pulse_n;

    logic [7:0]           err_count, err_count_n;
    logic [31:0]          err_addr, err_addr_n;
    logic [3:0]           err_slot, err_slot_n;
    logic                 err_to, err_to_n;

    logic                 log_err;
    logic [3:0]           log_slot;
    logic                 log_to;
    logic [31:0]          log_addr;

    logic                 dec_hit;
    logic [3:0]           dec_sel;
    logic [NSLAVES-1:0]   dec_onehot;
    logic                 is_status0, is_status1;
    logic                 sel_ready;
    logic [31:0]          sel_rdata;

    iomem_decode #(
        .NSLAVES (NSLAVES),
        .BASE    (BASE),
        .MASK    (MASK)
    ) u_decode (
        .addr (bus.m_addr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    assign is_status0 = (bus.m_addr == STATUS_ADDR);
    assign is_status1 = (bus.m_addr == STATUS_ADDR + 32'd4);

    always_comb begin
        dec_onehot = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            dec_onehot[i] = (dec_sel == 4'(i));
        end
    end

    // Only the selected slave's ready/rdata can reach the FSM.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (sel == 4'(i)) begin
                sel_ready = bus.s_ready[i];
                sel_rdata = bus.s_rdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        sel_n       = sel;
        s_valid_n   = s_valid_q;
        s_addr_n    = s_addr_q;
        s_wdata_n   = s_wdata_q;
        s_wstrb_n   = s_wstrb_q;
        m_ready_n   = 1'b0;
        m_rdata_n   = m_rdata_q;
        cnt_n       = cnt;
        err_pulse_n = 1'b0;
        err_count_n = err_count;
        err_addr_n  = err_addr;
        err_slot_n  = err_slot;
        err_to_n    = err_to;
        log_err     = 1'b0;
        log_slot    = '0;
        log_to      = 1'b0;
        log_addr    = '0;

        case (state)
            IDLE: begin
                if (bus.m_valid) begin
                    s_addr_n  = bus.m_addr;
                    s_wdata_n = bus.m_wdata;
                    s_wstrb_n = bus.m_wstrb;
                    if (is_status0 || is_status1) begin
                        state_n   = RESP;
                        m_ready_n = 1'b1;
                        m_rdata_n = is_status0 ? status_word0(err_to, err_slot, err_count)
                                               : err_addr;
                        // Word 1 is read-only: only word 0 writes clear the log.
                        if (is_status0 && (bus.m_wstrb != 4'b0000)) begin
                            err_count_n = '0;
                            err_slot_n  = '0;
                            err_to_n    = 1'b0;
                        end
                    end else if (dec_hit) begin
                        state_n   = ACCESS;
                        sel_n     = dec_sel;
                        s_valid_n = dec_onehot;
                        cnt_n     = '0;
                    end else begin
                        state_n     = RESP;
                        m_ready_n   = 1'b1;
                        m_rdata_n   = ERR_DATA;
                        err_pulse_n = 1'b1;
                        log_err     = 1'b1;
                        log_slot    = ERR_SLOT_DECODE;
                        log_to      = 1'b0;
                        log_addr    = bus.m_addr;
                    end
                end
            end
            ACCESS: begin
                // A ready arriving on the timeout cycle still wins.
                if (sel_ready) begin
                    state_n   = RESP;
                    s_valid_n = '0;
                    m_ready_n = 1'b1;
                    m_rdata_n = sel_rdata;
                end else if (cnt == CNT_LAST) begin
                    state_n     = RESP;
                    s_valid_n   = '0;
                    m_ready_n   = 1'b1;
                    m_rdata_n   = ERR_DATA;
                    err_pulse_n = 1'b1;
                    log_err     = 1'b1;
                    log_slot    = sel;
                    log_to      = 1'b1;
                    log_addr    = s_addr_q;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n   = IDLE;
                s_valid_n = '0;
            end
        endcase

        if (log_err) begin
            err_count_n = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
            err_addr_n  = log_addr;
            err_slot_n  = log_slot;
            err_to_n    = log_to;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel         <= '0;
            s_valid_q   <= '0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wstrb_q   <= '0;
            m_ready_q   <= 1'b0;
            m_rdata_q   <= '0;
            cnt         <= '0;
            err_pulse_q <= 1'b0;
            err_count   <= '0;
            err_addr    <= '0;
            err_slot    <= '0;
            err_to      <= 1'b0;
        end else begin
            sel         <= sel_n;
            s_valid_q   <= s_valid_n;
            s_addr_q    <= s_addr_n;
            s_wdata_q   <= s_wdata_n;
            s_wstrb_q   <= s_wstrb_n;
            m_ready_q   <= m_ready_n;
            m_rdata_q   <= m_rdata_n;
            cnt         <= cnt_n;
            err_pulse_q <= err_pulse_n;
            err_count   <= err_count_n;
            err_addr    <= err_addr_n;
            err_slot    <= err_slot_n;
            err_to      <= err_to_n;
        end
    end

    assign bus.m_ready = m_ready_q;
    assign bus.m_rdata = m_rdata_q;
    assign bus.s_valid = s_valid_q;
    assign bus.s_addr  = s_addr_q;
    assign bus.s_wdata = s_wdata_q;
    assign bus.s_wstrb = s_wstrb_q;
    assign err_pulse   = err_pulse_q;
    assign dbg_state   = state;

endmodule

// File: tb/tb_iomem_fabric.sv
// tb_iomem_fabric: randomized, scoreboard-checked bench for iomem_fabric.
// A reference model predicts each response from the address map, the error
// log rules and a per-slot memory; a monitor pops and compares on m_ready.
module tb_iomem_fabric;
    import iomem_pkg::*;

    localparam int NS = 6;
    localparam int TO = 15;
    localparam logic [31:0] STATUS_A = 32'h0300_0100;
    localparam logic [31:0] ERR_D    = 32'hDEAD_BEEF;
    // slot: 5            4             3             2             1             0
    localparam logic [32*NS-1:0] BASE_P = {32'h5000_0000, 32'h8000_0000, 32'h2000_0000,
                                           32'h0300_0000, 32'h8000_0000, 32'h1000_0000};
    localparam logic [32*NS-1:0] MASK_P = {32'hF000_0000, 32'hFF00_0000, 32'hFF00_0000,
                                           32'hFF00_0000, 32'hFFFF_FF00, 32'hFF00_0000};

    localparam int K_STATUS  = 0;
    localparam int K_DECERR  = 1;
    localparam int K_SLAVE   = 2;
    localparam int K_TIMEOUT = 3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        chk;
        logic        err;
    } exp_t;

    typedef struct {
        int          slot;
        logic [31:0] addr;
    } sel_t;

    logic   clk;
    logic   reset;
    logic   err_pulse;
    state_t dbg_state;

    iomem_if #(.NSLAVES(NS)) bus ();

    iomem_fabric #(
        .NSLAVES     (NS),
        .TIMEOUT     (TO),
        .BASE        (BASE_P),
        .MASK        (MASK_P),
        .STATUS_ADDR (STATUS_A),
        .ERR_DATA    (ERR_D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .err_pulse (err_pulse),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    sel_t sel_q[$];
    int   lat[NS];
    int   bfm_ready_cyc = 0;

    // reference model state
    logic [31:0] base_a[NS];
    logic [31:0] mask_a[NS];
    logic [7:0]  m_cnt;
    logic [31:0] m_eaddr;
    logic [3:0]  m_eslot;
    logic        m_eto;
    logic [31:0] ref_mem [longint];
    logic [31:0] smem    [longint];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint mkey(input int s, input logic [31:0] a);
        return longint'(s) * 64'sh1_0000_0000 + longint'({32'h0, a});
    endfunction

    // Contents a slave returns for a location never written.
    function automatic logic [31:0] slave_default(input int s, input logic [31:0] a);
        return a ^ (32'h0101_0101 * 32'(s)) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & mask_a[i]) == (base_a[i] & mask_a[i])) return i;
        end
        return -1;
    endfunction

    task automatic model_log(input logic [31:0] a, input logic [3:0] s, input logic to);
        m_cnt   = (m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1;
        m_eaddr = a;
        m_eslot = s;
        m_eto   = to;
    endtask

    task automatic model_clear_log();
        m_cnt = 0; m_eaddr = 0; m_eslot = 0; m_eto = 0;
    endtask

    task automatic model_access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                output logic [31:0] rd, output logic er,
                                output int kind, output int slot);
        logic [31:0] cur;
        longint      k;
        rd = '0; er = 1'b0; slot = -1; kind = K_STATUS;
        if (a == STATUS_A) begin
            rd = {m_eto, 15'b0, 4'b0, m_eslot, m_cnt};
            if (ws != 0) begin
                m_cnt = 0; m_eslot = 0; m_eto = 0;
            end
        end else if (a == STATUS_A + 4) begin
            rd = m_eaddr;
        end else begin
            slot = model_decode(a);
            if (slot < 0) begin
                kind = K_DECERR; rd = ERR_D; er = 1'b1;
                model_log(a, 4'hF, 1'b0);
            end else if (lat[slot] < 0) begin
                kind = K_TIMEOUT; rd = ERR_D; er = 1'b1;
                model_log(a, 4'(slot), 1'b1);
            end else begin
                kind = K_SLAVE;
                k = mkey(slot, a);
                cur = ref_mem.exists(k) ? ref_mem[k] : slave_default(slot, a);
                rd = cur;
                for (int b = 0; b < 4; b++) if (ws[b]) cur[8*b +: 8] = wd[8*b +: 8];
                ref_mem[k] = cur;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        exp_t        e;
        int          kind, slot, t0, tr;
        logic        got;
        logic [31:0] rd;
        logic        er;
        model_access(a, wd, ws, rd, er, kind, slot);
        e.rdata = rd; e.err = er; e.chk = (ws == 4'b0000);
        exp_q.push_back(e);
        if (kind == K_SLAVE || kind == K_TIMEOUT) sel_q.push_back('{slot: slot, addr: a});
        @(posedge clk); #1;
        bus.m_valid = 1'b1; bus.m_addr = a; bus.m_wdata = wd; bus.m_wstrb = ws;
        t0 = cyc;
        got = 1'b0;
        tr = 0;
        for (int k = 0; k < TO + 40; k++) begin
            @(negedge clk);
            if (bus.m_ready) begin got = 1'b1; tr = cyc; break; end
        end
        if (!got) begin
            n_vec++; n_fail++;
            $display("FAIL ready_wait: no m_ready for addr %h, expected one within %0d cycles", a, TO + 40);
        end else begin
            case (kind)
                K_SLAVE:   check("latency_slave",   32'(tr), 32'(bfm_ready_cyc + 1));
                K_TIMEOUT: check("latency_timeout", 32'(tr - t0), 32'(TO + 1));
                default:   check("latency_direct",  32'(tr - t0), 32'd1);
            endcase
        end
        @(posedge clk); #1;
        bus.m_valid = 1'b0; bus.m_wstrb = 4'b0000;
    endtask

    // ---------------- slave BFM ----------------
    initial begin
        int          idx, lat_now, hi;
        logic [31:0] cur;
        longint      k;
        sel_t        sx;
        bus.s_ready = '0;
        bus.s_rdata = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.s_valid != '0) begin
                idx = 0;
                for (int i = NS - 1; i >= 0; i--) if (bus.s_valid[i]) idx = i;
                if (sel_q.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL unexpected_s_valid: got s_valid=%b, expected none", bus.s_valid);
                end else begin
                    sx = sel_q.pop_front();
                    check("s_valid_onehot", 32'(bus.s_valid), 32'(1) << sx.slot);
                    check("s_addr", bus.s_addr, sx.addr);
                end
                lat_now = lat[idx];
                if (lat_now < 0) begin
                    hi = 0;
                    while (bus.s_valid[idx] && hi < 200) begin
                        hi++;
                        @(negedge clk);
                    end
                    check("timeout_len", 32'(hi), 32'(TO));
                end else begin
                    k   = mkey(idx, bus.s_addr);
                    cur = smem.exists(k) ? smem[k] : slave_default(idx, bus.s_addr);
                    for (int b = 0; b < 4; b++)
                        if (bus.s_wstrb[b]) cur[8*b +: 8] = bus.s_wdata[8*b +: 8];
                    smem[k] = cur;
                    repeat (lat_now) @(posedge clk);
                    #1;
                    bus.s_ready[idx] = 1'b1;
                    bus.s_rdata[32*idx +: 32] = cur;
                    bfm_ready_cyc = cyc;
                    @(posedge clk); #1;
                    bus.s_ready[idx] = 1'b0;
                    bus.s_rdata[32*idx +: 32] = 32'h0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_fail++;
                        $display("FAIL unexpected_m_ready: got m_ready=1, expected 0");
                    end else begin
                        e = exp_q.pop_front();
                        if (e.chk) check("m_rdata", bus.m_rdata, e.rdata);
                        check("err_pulse", 32'(err_pulse), 32'(e.err));
                    end
                end else if (err_pulse) begin
                    n_vec++; n_fail++;
                    $display("FAIL stray_err_pulse: got err_pulse=1 without m_ready, expected 0");
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [32*NS-1:0] bp, mp;
        logic [31:0]      a, off;
        logic [3:0]       ws;
        int               r;
        bp = BASE_P; mp = MASK_P;
        for (int i = 0; i < NS; i++) begin
            base_a[i] = bp[32*i +: 32];
            mask_a[i] = mp[32*i +: 32];
            lat[i] = 1;
        end
        lat[3] = -1;
        model_clear_log();

        reset = 1'b1;
        bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_ready",   32'(bus.m_ready), 32'd0);
        check("rst_m_rdata",   bus.m_rdata, 32'd0);
        check("rst_s_valid",   32'(bus.s_valid), 32'd0);
        check("rst_s_addr",    bus.s_addr, 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_state",     32'(dbg_state), 32'(IDLE));
        @(posedge clk); #1;
        reset = 1'b0;

        // Slot 2 read, slave ready 3 cycles after s_valid.
        smem[mkey(2, 32'h0300_0040)]    = 32'h1234_5678;
        ref_mem[mkey(2, 32'h0300_0040)] = 32'h1234_5678;
        lat[2] = 3;
        do_req(32'h0300_0040, 32'h0, 4'h0);
        do_req(STATUS_A, 32'h0, 4'h0);
        // Overlapping slots 1 and 4; combinational-speed ready on slot 1.
        lat[1] = 0;
        do_req(32'h8000_0010, 32'h0, 4'h0);
        do_req(32'h8000_0010, 32'hCAFE_F00D, 4'b0101);
        do_req(32'h8000_0010, 32'h0, 4'h0);
        // Decode error and log readback.
        do_req(32'h0400_0000, 32'h0, 4'h0);
        do_req(STATUS_A, 32'h0, 4'h0);
        do_req(STATUS_A + 4, 32'h0, 4'h0);
        // Timeouts on slot 3, then clear the log.
        do_req(32'h2000_0004, 32'h0, 4'h0);
        do_req(STATUS_A, 32'h0, 4'h0);
        do_req(32'h2000_0008, 32'h1111_2222, 4'hF);
        do_req(STATUS_A, 32'h0, 4'h0);
        do_req(STATUS_A + 4, 32'hFFFF_FFFF, 4'hF);
        do_req(STATUS_A, 32'h1, 4'hF);
        do_req(STATUS_A, 32'h0, 4'h0);
        do_req(STATUS_A + 4, 32'h0, 4'h0);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < NS; i++) if (i != 3) lat[i] = $urandom_range(0, 4);
            off = 32'($urandom_range(0, 255)) * 4;
            r   = $urandom_range(0, 9);
            case (r)
                0: a = 32'h1000_0000 | off;
                1: a = 32'h8000_0000 | (off & 32'hFF);
                2: a = 32'h8000_0000 | off;
                3: a = 32'h0300_0000 | off;
                4: a = 32'h2000_0000 | off;
                5: a = 32'h5000_0000 | off;
                6: a = 32'h0600_0000 | off;
                7: a = STATUS_A;
                8: a = STATUS_A + 4;
                default: a = $urandom;
            endcase
            ws = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            do_req(a, $urandom, ws);
        end

        // Saturation of the error counter.
        for (int n = 0; n < 300; n++) do_req(32'h0400_0000 + 32'(n) * 4, 32'h0, 4'h0);
        do_req(STATUS_A, 32'h0, 4'h0);

        // Reset two cycles into an ACCESS on slot 0 with a late ready.
        lat[0] = 8;
        sel_q.push_back('{slot: 0, addr: 32'h1000_0020});
        @(posedge clk); #1;
        bus.m_valid = 1'b1; bus.m_addr = 32'h1000_0020; bus.m_wstrb = 4'h0;
        @(posedge clk); #1;
        bus.m_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear_log();
        @(negedge clk);
        check("rstacc_s_valid", 32'(bus.s_valid), 32'd0);
        check("rstacc_m_ready", 32'(bus.m_ready), 32'd0);
        check("rstacc_m_rdata", bus.m_rdata, 32'd0);
        check("rstacc_state",   32'(dbg_state), 32'(IDLE));
        repeat (15) @(posedge clk);
        check("rstacc_idle_after_late_ready", 32'(dbg_state), 32'(IDLE));
        lat[0] = 1;
        do_req(32'h1000_0020, 32'h0, 4'h0);
        do_req(STATUS_A, 32'h0, 4'h0);
        do_req(STATUS_A + 4, 32'h0, 4'h0);

        repeat (5) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("sel_q_drained", 32'(sel_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
